// File: rtl/pc_fetch.sv
// pc_fetch: fetch unit keeping at most DEPTH requests in flight or buffered, with
// in-order response matching and redirect flush of stale responses.
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
);
  localparam logic [2:0] DEPTH_W = 3'(DEPTH);
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [1:0]  inflight_q, inflight_d, drop_cnt_q, drop_cnt_d, f_cnt_q, f_cnt_d;
  logic        pq_wr_q, pq_wr_d, pq_rd_q, pq_rd_d, f_wr_q, f_wr_d, f_rd_q, f_rd_d;
  logic [31:0] pq_pc_q [2];
  logic [31:0] f_pc_q [2];
  logic [31:0] f_instr_q [2];
  logic        req_fire, rsp_fire, if_fire, keep;
  logic [2:0]  occ;

  assign if_valid = f_cnt_q != 2'd0;
  assign if_fire  = if_valid && if_ready;
  assign if_pc    = f_pc_q[f_rd_q];
  assign if_instr = f_instr_q[f_rd_q];
  // a same-cycle hand-off to decode frees a slot, sustaining one fetch per cycle
  assign occ            = {1'b0, inflight_q} + {1'b0, f_cnt_q} - {2'b0, if_fire};
  assign imem_req_valid = rstn && !stall && !redirect_valid && occ < DEPTH_W;
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_fire       = imem_rsp_valid && inflight_q != 2'd0;
  assign keep           = rsp_fire && drop_cnt_q == 2'd0 && !redirect_valid;

  always_comb begin
    fetch_pc_d = redirect_valid ? {redirect_pc[31:2], 2'b00} : req_fire ? fetch_pc_q + 32'd4 : fetch_pc_q;
    inflight_d = inflight_q + {1'b0, req_fire} - {1'b0, rsp_fire};
    drop_cnt_d = redirect_valid ? inflight_d : (rsp_fire && drop_cnt_q != 2'd0) ? drop_cnt_q - 2'd1 : drop_cnt_q;
    pq_wr_d    = pq_wr_q ^ req_fire;
    pq_rd_d    = pq_rd_q ^ rsp_fire;
    f_wr_d     = redirect_valid ? 1'b0 : f_wr_q ^ keep;
    f_rd_d     = redirect_valid ? 1'b0 : f_rd_q ^ if_fire;
    f_cnt_d    = redirect_valid ? 2'd0 : f_cnt_q + {1'b0, keep} - {1'b0, if_fire};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fetch_pc_q <= {RESET_PC[31:2], 2'b00};
      inflight_q <= 2'd0;
      drop_cnt_q <= 2'd0;
      f_cnt_q    <= 2'd0;
      pq_wr_q    <= 1'b0;
      pq_rd_q    <= 1'b0;
      f_wr_q     <= 1'b0;
      f_rd_q     <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      drop_cnt_q <= drop_cnt_d;
      f_cnt_q    <= f_cnt_d;
      pq_wr_q    <= pq_wr_d;
      pq_rd_q    <= pq_rd_d;
      f_wr_q     <= f_wr_d;
      f_rd_q     <= f_rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) pq_pc_q[pq_wr_q] <= fetch_pc_q;
    if (keep) begin
      f_pc_q[f_wr_q]    <= pq_pc_q[pq_rd_q];
      f_instr_q[f_wr_q] <= imem_rsp_data;
    end
  end
endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: directed and randomized checks of pc_fetch against a program-order
// reference model with an in-order memory responder.
module tb_pc_fetch;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        stall = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        if_valid;
  logic        if_ready = 1'b1;
  logic [31:0] if_pc, if_instr;

  pc_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk(clk), .rstn(rstn), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .stall(stall), .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr)
  );

  always #5 clk = ~clk;

  int          checks = 0, failures = 0, xfers = 0, accepts = 0, rsp_pct = 100;
  logic        spur = 1'b0, prev_redir = 1'b0;
  logic        s_req_v, s_ifv, s_if_fire, s_acc;
  logic [31:0] s_addr, s_if_pc, m_req_pc, m_if_pc;
  logic [31:0] mq [$];

  function automatic logic [31:0] word(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    s_req_v   = imem_req_valid;
    s_addr    = imem_req_addr;
    s_ifv     = if_valid;
    s_if_pc   = if_pc;
    s_if_fire = if_valid && if_ready;
    s_acc     = imem_req_valid && imem_req_ready;
    if (prev_redir) chk("if_valid_after_redirect", 32'(s_ifv), 32'd0);
    if (stall || redirect_valid) chk("req_blocked", 32'(s_req_v), 32'd0);
    if (s_req_v) chk("req_addr", s_addr, m_req_pc);
    chk("outstanding_le_2", 32'(mq.size() <= 2), 32'd1);
    if (s_if_fire) begin
      chk("if_pc", if_pc, m_if_pc);
      chk("if_instr", if_instr, word(m_if_pc));
      m_if_pc += 32'd4;
      xfers++;
    end
    if (redirect_valid) begin
      m_req_pc = {redirect_pc[31:2], 2'b00};
      m_if_pc  = m_req_pc;
    end
    if (s_acc) begin
      mq.push_back(s_addr);
      m_req_pc += 32'd4;
      accepts++;
    end
    if (imem_rsp_valid && mq.size() != 0) void'(mq.pop_front());
    prev_redir = redirect_valid;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom();
    if (mq.size() != 0 && int'($urandom_range(99)) < rsp_pct) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = word(mq[0]);
    end else if (mq.size() == 0 && spur) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hDEAD_BEEF;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rstn = 1'b0;
    mq.delete();
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("reset_req_valid", 32'(imem_req_valid), 32'd0);
    chk("reset_if_valid", 32'(if_valid), 32'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    m_req_pc = 32'h0;
    m_if_pc = 32'h0;
    prev_redir = 1'b0;
    accepts = 0;
    xfers = 0;
  endtask

  initial begin
    int q0, x0;
    logic found;
    logic [31:0] a;
    do_reset();
    tick();
    chk("first_req_valid", 32'(s_req_v), 32'd1);
    chk("first_req_addr", s_addr, 32'h0);
    tick();
    chk("req1_addr", s_addr, 32'h4);
    tick();
    chk("req2_addr", s_addr, 32'h8);
    chk("if0_fire", 32'(s_if_fire), 32'd1);
    chk("if0_pc", s_if_pc, 32'h0);
    tick();
    chk("if1_pc", s_if_fire ? s_if_pc : 32'hFFFF_FFFF, 32'h4);
    tick();
    chk("if2_pc", s_if_fire ? s_if_pc : 32'hFFFF_FFFF, 32'h8);

    do_reset();
    if_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("backpressure_occupancy", 32'((accepts - xfers) <= 2), 32'd1);
    end
    chk("backpressure_req_low", 32'(s_req_v), 32'd0);
    chk("backpressure_head_valid", 32'(s_ifv), 32'd1);
    chk("backpressure_head_pc", s_if_pc, 32'h0);
    if_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    chk("backpressure_resume_count", 32'(xfers >= 4), 32'd1);

    do_reset();
    rsp_pct = 100;
    tick();
    tick();
    rsp_pct = 0;
    tick();
    tick();
    chk("two_inflight", 32'(mq.size()), 32'd2);
    chk("inflight_head", mq.size() == 2 ? mq[0] : 32'hFFFF_FFFF, 32'h8);
    chk("inflight_tail", mq.size() == 2 ? mq[1] : 32'hFFFF_FFFF, 32'hC);
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    rsp_pct = 100;
    tick();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      found = s_if_fire;
    end
    chk("redirect_first_if_seen", 32'(found), 32'd1);
    chk("redirect_first_if_pc", s_if_pc, 32'h100);

    redirect_valid = 1'b1;
    redirect_pc = 32'h203;
    tick();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      found = s_req_v;
    end
    chk("unaligned_redirect_req_seen", 32'(found), 32'd1);
    chk("unaligned_redirect_addr", s_addr, 32'h200);

    do_reset();
    rsp_pct = 0;
    tick();
    tick();
    q0 = mq.size();
    chk("stall_setup_inflight", 32'(q0), 32'd2);
    x0 = xfers;
    stall = 1'b1;
    rsp_pct = 100;
    for (int i = 0; i < 5; i++) tick();
    chk("stall_drained", 32'(mq.size()), 32'd0);
    chk("stall_delivered", 32'(xfers - x0), 32'(q0));
    spur = 1'b1;
    tick();
    spur = 1'b0;
    tick();
    tick();
    chk("spurious_rsp_ignored", 32'(s_ifv), 32'd0);
    stall = 1'b0;
    imem_req_ready = 1'b0;
    tick();
    a = s_addr;
    chk("notready_req_valid", 32'(s_req_v), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("notready_addr_stable", s_req_v ? s_addr : 32'hFFFF_FFFF, a);
    end
    imem_req_ready = 1'b1;

    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFE;
    tick();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      found = s_acc;
    end
    chk("wrap_top_accepted", 32'(found), 32'd1);
    chk("wrap_top_addr", s_addr, 32'hFFFF_FFFC);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      found = s_acc;
    end
    chk("wrap_next_accepted", 32'(found), 32'd1);
    chk("wrap_next_addr", s_addr, 32'h0);

    for (int i = 0; i < 2000; i++) begin
      stall          = ($urandom_range(4) == 0);
      imem_req_ready = ($urandom_range(3) != 0);
      if_ready       = ($urandom_range(3) != 0);
      rsp_pct        = 60;
      if ($urandom_range(19) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc    = $urandom();
      end
      tick();
    end
    stall = 1'b0;
    imem_req_ready = 1'b1;
    if_ready = 1'b1;
    rsp_pct = 100;
    x0 = xfers;
    for (int i = 0; i < 20; i++) tick();
    chk("final_flow_resumes", 32'(xfers - x0 >= 10), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
